// File: rtl/vending_pkg.sv
// vending_pkg
// Shared types and constants for the vending controller slice.
//   state_t        : controller states (COLLECT, VEND, CHANGE)
//   SLOT_*         : bit positions of the coin slots in coin_req/coin_gnt
//   VAL_*          : value of each coin in nickels
//   coin_value()   : maps a one-hot (or zero) grant vector to its value
package vending_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_CHANGE  = 2'd2
    } state_t;

    localparam int NUM_SLOTS    = 3;
    localparam int SLOT_NICKEL  = 0;
    localparam int SLOT_DIME    = 1;
    localparam int SLOT_QUARTER = 2;

    localparam logic [2:0] VAL_NICKEL  = 3'd1;
    localparam logic [2:0] VAL_DIME    = 3'd2;
    localparam logic [2:0] VAL_QUARTER = 3'd5;

    // A zero grant is worth nothing, so the adder can run unconditionally.
    function automatic logic [2:0] coin_value(input logic [2:0] gnt);
        logic [2:0] v;
        v = 3'd0;
        case (gnt)
            3'b001:  v = VAL_NICKEL;
            3'b010:  v = VAL_DIME;
            3'b100:  v = VAL_QUARTER;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_arbiter.sv
// coin_arbiter
// Picks at most one requesting coin slot per cycle.
// Build option: define ARB_RR_EN for round-robin arbitration (search starts
// at the slot after the last granted one); otherwise fixed priority
// quarter > dime > nickel with no state.
// Ports:
//   i_clk, i_rst_n : clock and async active-low reset (used by round-robin only)
//   i_enable       : grants allowed this cycle
//   i_req[2:0]     : slot requests ([0]=nickel, [1]=dime, [2]=quarter)
//   o_gnt[2:0]     : one-hot grant or zero, combinational
module coin_arbiter
    import vending_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [2:0] i_req,
    output logic [2:0] o_gnt
);

`ifdef ARB_RR_EN
    // r_ptr holds the slot where the next search begins, not the last winner.
    logic [1:0] r_ptr;
    logic [1:0] w_idx;
    logic [1:0] w_gnt_idx;
    logic       w_found;

    // Walk the slots starting at the pointer and take the first requester.
    always_comb begin
        o_gnt     = 3'b000;
        w_idx     = 2'd0;
        w_gnt_idx = 2'd0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_idx = 2'((int'(r_ptr) + i) % NUM_SLOTS);
            if (i_enable && !w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_gnt_idx    = w_idx;
                w_found      = 1'b1;
            end
        end
    end

    // The pointer only moves when something was actually granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 2'd0;
        end else if (w_found) begin
            r_ptr <= (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n;

    // Highest-value coin first.
    always_comb begin
        o_gnt = 3'b000;
        if (i_enable) begin
            if (i_req[SLOT_QUARTER]) begin
                o_gnt[SLOT_QUARTER] = 1'b1;
            end else if (i_req[SLOT_DIME]) begin
                o_gnt[SLOT_DIME] = 1'b1;
            end else if (i_req[SLOT_NICKEL]) begin
                o_gnt[SLOT_NICKEL] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/vending_controller.sv
// vending_controller
// Coin-collecting vending FSM: accumulates credit, vends once credit reaches
// PRICE, then returns any remainder one nickel per cycle. A cancel in COLLECT
// refunds the whole credit.
// Build option: ARB_RR_EN selects round-robin coin arbitration (see coin_arbiter).
// Parameters: PRICE (nickels), CREDIT_W (credit register width).
// Ports:
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_coin_req[2:0] : level-held coin requests ([0]=nickel,[1]=dime,[2]=quarter)
//   i_cancel        : refund request, honoured only in COLLECT
//   o_coin_gnt[2:0] : combinational one-hot grant or zero
//   o_dispense      : one-cycle vend pulse
//   o_change        : one pulse per nickel returned
//   o_busy          : high while vending or returning change
//   o_credit        : current credit in nickels (registered)
module vending_controller
    import vending_pkg::*;
#(
    parameter int PRICE    = 7,
    parameter int CREDIT_W = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [2:0]          i_coin_req,
    input  logic                i_cancel,
    output logic [2:0]          o_coin_gnt,
    output logic                o_dispense,
    output logic                o_change,
    output logic                o_busy,
    output logic [CREDIT_W-1:0] o_credit
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_next;
    logic [CREDIT_W-1:0] w_sum;
    logic [CREDIT_W-1:0] w_rem;
    logic [2:0]          w_gnt;
    logic                w_arb_en;

    // Reset is folded in so no grant can leak out while the block is held in reset.
    assign w_arb_en = i_rst_n && (r_state == ST_COLLECT) && !i_cancel;

    coin_arbiter u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (w_arb_en),
        .i_req    (i_coin_req),
        .o_gnt    (w_gnt)
    );

    assign w_sum      = r_credit + CREDIT_W'(coin_value(w_gnt));
    assign w_rem      = r_credit - PRICE_C;
    assign o_coin_gnt = w_gnt;
    assign o_credit   = r_credit;

    // Next-state, next-credit and pulse outputs; the change state counts the
    // credit register down to zero so it doubles as the refund counter.
    always_comb begin
        w_state_next  = r_state;
        w_credit_next = r_credit;
        o_dispense    = 1'b0;
        o_change      = 1'b0;
        o_busy        = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (i_cancel) begin
                    if (r_credit != '0) begin
                        w_state_next = ST_CHANGE;
                    end
                end else if (w_gnt != 3'b000) begin
                    w_credit_next = w_sum;
                    if (w_sum >= PRICE_C) begin
                        w_state_next = ST_VEND;
                    end
                end
            end
            ST_VEND: begin
                o_dispense    = 1'b1;
                o_busy        = 1'b1;
                w_credit_next = w_rem;
                w_state_next  = (w_rem != '0) ? ST_CHANGE : ST_COLLECT;
            end
            ST_CHANGE: begin
                o_busy = 1'b1;
                if (r_credit != '0) begin
                    o_change      = 1'b1;
                    w_credit_next = r_credit - ONE_C;
                end
                if (r_credit <= ONE_C) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    // State and credit registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_COLLECT;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_next;
            r_credit <= w_credit_next;
        end
    end

endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller
// Directed scenarios for vending_controller (PRICE=7) with a transaction-level
// model checked every cycle, plus literal expectations for each scenario.
module tb_vending_controller;

    localparam int PRICE    = 7;
    localparam int CREDIT_W = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [2:0]          coinReq;
    logic                cancel;
    logic [2:0]          dutGnt;
    logic                dutDispense;
    logic                dutChange;
    logic                dutBusy;
    logic [CREDIT_W-1:0] dutCredit;

    int errors = 0;
    int checks = 0;

    int dispCount   = 0;
    int changeCount = 0;
    int busyCount   = 0;
    logic [2:0] lastGnt;
    logic       lastBusy;
    int         lastCredit;

    // Model: credit in nickels, a pending vend flag, a refund-in-progress flag,
    // and the round-robin search start.
    int mCredit    = 0;
    bit mVend      = 0;
    bit mRefunding = 0;
    int mPtr       = 0;

    vending_controller #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_coin_req (coinReq),
        .i_cancel   (cancel),
        .o_coin_gnt (dutGnt),
        .o_dispense (dutDispense),
        .o_change   (dutChange),
        .o_busy     (dutBusy),
        .o_credit   (dutCredit)
    );

    always #5 clk = ~clk;

    function automatic int coinWorth(input int slot);
        if (slot == 0) return 1;
        if (slot == 1) return 2;
        return 5;
    endfunction

    // Which requester should win, given the requests and the search start.
    function automatic int chooseSlot(input logic [2:0] req, input int ptr);
        int best;
        int bestVal;
        best = -1;
        bestVal = 0;
`ifdef ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (ptr + k) % 3;
            if (best < 0 && req[s]) best = s;
        end
`else
        for (int s = 0; s < 3; s++) begin
            if (req[s] && coinWorth(s) > bestVal) begin
                best = s;
                bestVal = coinWorth(s);
            end
        end
        bestVal = ptr;
`endif
        return best;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance
    // the model by what the coming rising edge should do.
    task automatic compareModel();
        int eGnt, eDisp, eChg, eBusy, eCredit, pick;
        pick = -1;
        if (!rst_n) begin
            mCredit = 0; mVend = 0; mRefunding = 0; mPtr = 0;
            eGnt = 0; eDisp = 0; eChg = 0; eBusy = 0; eCredit = 0;
        end else begin
            eBusy   = (mVend || mRefunding) ? 1 : 0;
            eDisp   = mVend ? 1 : 0;
            eChg    = mRefunding ? 1 : 0;
            eCredit = mCredit;
            if (eBusy == 0 && !cancel) pick = chooseSlot(coinReq, mPtr);
            eGnt = (pick < 0) ? 0 : (1 << pick);
        end
        checkOutput("model coin_gnt", int'(dutGnt), eGnt);
        checkOutput("model dispense", int'(dutDispense), eDisp);
        checkOutput("model change", int'(dutChange), eChg);
        checkOutput("model busy", int'(dutBusy), eBusy);
        checkOutput("model credit", int'(dutCredit), eCredit);
        if (rst_n) begin
            if (mVend) begin
                mCredit    = mCredit - PRICE;
                mVend      = 0;
                mRefunding = (mCredit > 0);
            end else if (mRefunding) begin
                mCredit    = mCredit - 1;
                mRefunding = (mCredit > 0);
            end else if (cancel) begin
                if (mCredit > 0) mRefunding = 1;
            end else if (pick >= 0) begin
                mCredit = mCredit + coinWorth(pick);
                if (mCredit >= PRICE) mVend = 1;
                mPtr = (pick + 1) % 3;
            end
        end
    endtask

    // One clock cycle: check on the falling edge, resume 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        compareModel();
        lastGnt    = dutGnt;
        lastBusy   = dutBusy;
        lastCredit = int'(dutCredit);
        if (dutDispense) dispCount++;
        if (dutChange) changeCount++;
        if (dutBusy) busyCount++;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic cxl);
        coinReq = req;
        cancel  = cxl;
        tick();
    endtask

    // Hold a slot request until it is granted, then drop it.
    task automatic insertCoin(input int slot);
        bit granted;
        granted = 0;
        coinReq[slot] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (lastGnt[slot]) begin
                granted = 1;
                break;
            end
        end
        coinReq[slot] = 1'b0;
        checkOutput($sformatf("grant slot %0d", slot), int'(granted), 1);
    endtask

    task automatic cancelPulse();
        applyStimulus(coinReq, 1'b1);
        cancel = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit done;
        done = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!lastBusy && lastCredit == 0) begin
                done = 1;
                break;
            end
        end
        checkOutput({"idle reached ", name}, int'(done), 1);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(3'b111, 1'b0);
        checkOutput("reset grant suppressed", int'(lastGnt), 0);
        applyStimulus(3'b000, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int d0, c0, b0;
        int grants[$];
        int expGrants[$];

        rst_n   = 1'b0;
        coinReq = 3'b000;
        cancel  = 1'b0;
        applyReset();
        checkOutput("reset credit", int'(dutCredit), 0);
        checkOutput("reset busy", int'(dutBusy), 0);

        // Quarter then dime: exact price, no change.
        d0 = dispCount; c0 = changeCount;
        insertCoin(2);
        checkOutput("qd credit after quarter", int'(dutCredit), 5);
        insertCoin(1);
        checkOutput("qd credit after dime", int'(dutCredit), 7);
        checkOutput("qd dispense after dime grant", int'(dutDispense), 1);
        waitIdle("qd");
        checkOutput("qd dispense count", dispCount - d0, 1);
        checkOutput("qd change count", changeCount - c0, 0);

        // Quarter then quarter: 3 nickels back, busy 4 cycles.
        d0 = dispCount; c0 = changeCount; b0 = busyCount;
        insertCoin(2);
        insertCoin(2);
        checkOutput("qq credit", int'(dutCredit), 10);
        waitIdle("qq");
        checkOutput("qq dispense count", dispCount - d0, 1);
        checkOutput("qq change count", changeCount - c0, 3);
        checkOutput("qq busy cycles", busyCount - b0, 4);

        // Nickel, dime, cancel: full refund of 3.
        d0 = dispCount; c0 = changeCount;
        insertCoin(0);
        insertCoin(1);
        checkOutput("ndc credit", int'(dutCredit), 3);
        cancelPulse();
        waitIdle("ndc");
        checkOutput("ndc change count", changeCount - c0, 3);
        checkOutput("ndc dispense count", dispCount - d0, 0);

        // Cancel with no credit does nothing.
        cancelPulse();
        applyStimulus(3'b000, 1'b0);
        checkOutput("empty cancel busy", int'(lastBusy), 0);
        checkOutput("empty cancel credit", lastCredit, 0);

        // Cancel beats a dime request with credit 4.
        d0 = dispCount; c0 = changeCount;
        insertCoin(1);
        insertCoin(1);
        checkOutput("cancel-race credit", int'(dutCredit), 4);
        applyStimulus(3'b010, 1'b1);
        checkOutput("cancel-race grant", int'(lastGnt), 0);
        coinReq = 3'b000;
        cancel  = 1'b0;
        waitIdle("cancel-race");
        checkOutput("cancel-race change count", changeCount - c0, 4);
        checkOutput("cancel-race dispense count", dispCount - d0, 0);

        // All three slots held: arbitration order from a fresh reset.
        applyReset();
        coinReq = 3'b111;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (lastGnt != 3'b000) grants.push_back(int'(lastGnt));
            if (lastBusy) break;
        end
        coinReq = 3'b000;
        waitIdle("all-held");
`ifdef ARB_RR_EN
        expGrants = '{1, 2, 4};
`else
        expGrants = '{4, 4};
`endif
        checkOutput("all-held grant count", grants.size(), expGrants.size());
        for (int i = 0; i < expGrants.size() && i < grants.size(); i++) begin
            checkOutput($sformatf("all-held grant %0d", i), grants[i], expGrants[i]);
        end

        // Reset during the second change pulse of a quarter-quarter vend.
        insertCoin(2);
        insertCoin(2);
        tick();
        tick();
        checkOutput("mid-change pulse present", int'(dutChange), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset drops change", int'(dutChange), 0);
        checkOutput("reset clears credit", int'(dutCredit), 0);
        checkOutput("reset clears busy", int'(dutBusy), 0);
        tick();
        rst_n = 1'b1;
        c0 = changeCount; d0 = dispCount;
        for (int n = 0; n < 4; n++) tick();
        checkOutput("after reset no change", changeCount - c0, 0);
        checkOutput("after reset no dispense", dispCount - d0, 0);
        checkOutput("after reset credit", lastCredit, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameter PRICE, default 7: item price in nickels, 1..(2^CREDIT_W - 5).
REQ-002 Parameter CREDIT_W, default 6: credit register width in bits.
REQ-003 CLK  input  1: single clock; all state is on the rising edge.
REQ-004 RST_N  input  1: asynchronous, active-low reset.
REQ-005 coin_req  input  3: coin slot requests, level-held until granted; [0]=nickel(1), [1]=dime(2), [2]=quarter(5).
REQ-006 cancel  input  1: refund request; sampled only in COLLECT.
REQ-007 coin_gnt  output  3: one-hot or zero; combinational grant to the selected slot.
REQ-008 dispense  output  1: single-cycle vend pulse.
REQ-009 change  output  1: one-cycle pulse per nickel returned.
REQ-010 busy  output  1: high in VEND and CHANGE.
REQ-011 credit  output  CREDIT_W: current credit in nickels (registered).

Function
REQ-012 States SHALL be: COLLECT, VEND, CHANGE.
REQ-013 In COLLECT with cancel=0, coin_gnt SHALL select exactly one requesting slot, or none when coin_req=0.
REQ-014 In VEND or CHANGE, or when cancel=1, coin_gnt SHALL be 0.
REQ-015 On a granted edge, credit SHALL increase by the slot value (1/2/5); requesters drop their request after that edge.
REQ-016 If the post-add credit is >= PRICE, the next state SHALL be VEND; otherwise it stays COLLECT.
REQ-017 In VEND, dispense SHALL be 1 for exactly one cycle; on exit, credit SHALL become credit-PRICE.
REQ-018 From VEND, the next state SHALL be CHANGE if the remainder is >0, else COLLECT.
REQ-019 In CHANGE, change SHALL be 1 each cycle while credit>0, and credit SHALL decrement by 1 per cycle.
REQ-020 CHANGE SHALL return to COLLECT on the edge where credit reaches 0.
REQ-021 Latency: grant at cycle t, credit visible at t+1, dispense at t+1, first change pulse at t+2.
REQ-022 cancel=1 in COLLECT with credit>0: next state CHANGE, all credit refunded, no dispense.
REQ-023 cancel=1 with credit=0: no effect.
REQ-024 cancel and coin_req in the same cycle: cancel wins and the coin is not granted.
REQ-025 Credit SHALL never exceed PRICE+4; no overflow is possible within the PRICE range.
REQ-026 cancel and coin_req SHALL be ignored in VEND and CHANGE.

Reset
REQ-027 RST_N=0 SHALL immediately force state=COLLECT, credit=0, and the round-robin pointer to slot 0.
REQ-028 During reset, dispense, change, busy and coin_gnt SHALL be 0.
REQ-029 Reset mid-VEND or mid-CHANGE SHALL abandon the transaction with no further pulses; the pending refund is lost.

Configuration
REQ-030 Macro ARB_RR_EN defined: round-robin arbitration; search starts at the slot after the last granted one; the pointer updates only on a grant.
REQ-031 Macro ARB_RR_EN undefined: fixed priority quarter > dime > nickel; no pointer register exists.

Structure
REQ-032 Package vending_pkg SHALL hold the state enum, the slot index constants and the coin value constants (1, 2, 5).
REQ-033 Sub-module coin_arbiter SHALL contain all grant logic, including the ARB_RR_EN variant.
REQ-034 The credit and state registers SHALL reside in vending_controller.

Verification (PRICE=7)
REQ-035 Quarter, then dime: credit 5 -> 7; dispense on the cycle after the dime grant; credit -> 0; no change pulses.
REQ-036 Quarter, then quarter: credit 10; dispense; exactly 3 change pulses on consecutive cycles; credit -> 0; busy high for 4 cycles.
REQ-037 Nickel, then dime, then cancel: credit 3; exactly 3 change pulses; dispense never asserted.
REQ-038 coin_req=3'b111 held: without ARB_RR_EN, grants go quarter, quarter...; with ARB_RR_EN, grants rotate nickel, dime, quarter.
REQ-039 coin_req=3'b010 and cancel in the same cycle with credit=4: coin_gnt=0; 4 change pulses follow.
REQ-040 RST_N low on the 2nd change pulse of REQ-036: change drops immediately; credit=0; state COLLECT after release.
